// File: rtl/bster_mem_pkg.sv
// Shared AXI encodings, size decode helper and command layout for the BST memory port.
package bster_mem_pkg;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  typedef logic [1:0] axi_burst_t;
  localparam axi_burst_t BURST_FIXED = 2'b00;
  localparam axi_burst_t BURST_INCR  = 2'b01;
  localparam axi_burst_t BURST_WRAP  = 2'b10;

  // AXI AxSIZE for a bus of data_width bits (8..1024).
  function automatic logic [2:0] sizedec(input int unsigned data_width);
    logic [2:0] r_size;
    r_size = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd8 << i) == data_width) r_size = i[2:0];
    end
    return r_size;
  endfunction

  // Command layout at the default bus geometry; the port builds its own at its parameters.
  localparam int unsigned CMD_ADDR_W = 16;
  localparam int unsigned CMD_DATA_W = 32;

  typedef struct packed {
    logic                  is_rd;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } mem_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; head entry visible on o_rdata.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW:0]    r_wptr;
  logic [PtrW:0]    r_rptr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_wptr == r_rptr);
  // Extra pointer bit separates full from empty when the indices match.
  assign o_full  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                   (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
  assign o_rdata = r_mem[r_rptr[PtrW-1:0]];

  // Pointer update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[PtrW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/axi4_mem_port.sv
// BST engine memory bus to single-beat AXI4 master bridge with in-order command queue.
// Optional feature: define AXI_RESP_CHECK_EN to flag non-OKAY responses and illegal commands
// on mem_error; otherwise mem_error is tied low.
module axi4_mem_port
  import bster_mem_pkg::*;
#(
  parameter int unsigned RAM_DATA_WIDTH  = 32,
  parameter int unsigned RAM_ADDR_WIDTH  = 16,
  parameter int unsigned RAM_STRB_WIDTH  = RAM_DATA_WIDTH / 8,
  parameter int unsigned RAM_ID_WIDTH    = 8,
  parameter int unsigned CMD_DEPTH       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      aclk,
  input  logic                      srst,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic                      mem_rd,
  input  logic                      mem_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
  output logic                      mem_rd_valid,
  output logic [RAM_DATA_WIDTH-1:0] mem_rd_data,
  output logic                      mem_error,
  output logic [RAM_ID_WIDTH-1:0]   ram_axi_awid,
  output logic [RAM_ADDR_WIDTH-1:0] ram_axi_awaddr,
  output logic [7:0]                ram_axi_awlen,
  output logic [2:0]                ram_axi_awsize,
  output logic [1:0]                ram_axi_awburst,
  output logic                      ram_axi_awlock,
  output logic [3:0]                ram_axi_awcache,
  output logic [2:0]                ram_axi_awprot,
  output logic                      ram_axi_awvalid,
  input  logic                      ram_axi_awready,
  output logic [RAM_DATA_WIDTH-1:0] ram_axi_wdata,
  output logic [RAM_STRB_WIDTH-1:0] ram_axi_wstrb,
  output logic                      ram_axi_wlast,
  output logic                      ram_axi_wvalid,
  input  logic                      ram_axi_wready,
  input  logic [RAM_ID_WIDTH-1:0]   ram_axi_bid,
  input  logic [1:0]                ram_axi_bresp,
  input  logic                      ram_axi_bvalid,
  output logic                      ram_axi_bready,
  output logic [RAM_ID_WIDTH-1:0]   ram_axi_arid,
  output logic [RAM_ADDR_WIDTH-1:0] ram_axi_araddr,
  output logic [7:0]                ram_axi_arlen,
  output logic [2:0]                ram_axi_arsize,
  output logic [1:0]                ram_axi_arburst,
  output logic                      ram_axi_arlock,
  output logic [3:0]                ram_axi_arcache,
  output logic [2:0]                ram_axi_arprot,
  output logic                      ram_axi_arvalid,
  input  logic                      ram_axi_arready,
  input  logic [RAM_ID_WIDTH-1:0]   ram_axi_rid,
  input  logic [RAM_DATA_WIDTH-1:0] ram_axi_rdata,
  input  logic [1:0]                ram_axi_rresp,
  input  logic                      ram_axi_rlast,
  input  logic                      ram_axi_rvalid,
  output logic                      ram_axi_rready
);

  localparam int unsigned PendW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PendW-1:0] MaxPend = PendW'(MAX_OUTSTANDING);
  localparam logic [PendW-1:0] PendOne = PendW'(1);
  localparam logic [2:0] AxiSize = sizedec(RAM_DATA_WIDTH);

  typedef struct packed {
    logic                      is_rd;
    logic [RAM_ADDR_WIDTH-1:0] addr;
    logic [RAM_DATA_WIDTH-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_t;

  state_t             r_state;
  state_t             w_state_d;
  cmd_t               w_head;
  cmd_t               w_push_cmd;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               r_aw_done;
  logic               r_w_done;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_ar_hs;
  logic               w_b_hs;
  logic               w_r_hs;
  logic               w_r_done;
  logic               w_wr_fin;
  logic [PendW-1:0]   r_rd_pend;
  logic [PendW-1:0]   r_wr_pend;

  // Command queue; malformed commands (rd==wr) are accepted but never stored.
  assign mem_ready  = ~srst & ~w_full;
  assign w_push     = mem_valid & mem_ready & (mem_rd ^ mem_wr);
  assign w_push_cmd = '{is_rd: mem_rd, addr: mem_addr, data: mem_wr_data};

  sync_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_cmd_fifo (
    .i_clk   (aclk),
    .i_rst   (srst),
    .i_push  (w_push),
    .i_wdata (w_push_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_aw_hs  = ram_axi_awvalid & ram_axi_awready;
  assign w_w_hs   = ram_axi_wvalid & ram_axi_wready;
  assign w_ar_hs  = ram_axi_arvalid & ram_axi_arready;
  assign w_b_hs   = ram_axi_bvalid & ram_axi_bready;
  assign w_r_hs   = ram_axi_rvalid & ram_axi_rready;
  assign w_r_done = w_r_hs & ram_axi_rlast;
  assign w_wr_fin = (r_state == StWr) & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_pop    = w_wr_fin | w_ar_hs;

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (srst) r_state <= StIdle;
    else      r_state <= w_state_d;
  end

  // Next state; a direction switch waits for the other direction to drain fully.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          if (!w_head.is_rd && (r_rd_pend == '0) && (r_wr_pend < MaxPend)) begin
            w_state_d = StWr;
          end else if (w_head.is_rd && (r_wr_pend == '0) && (r_rd_pend < MaxPend)) begin
            w_state_d = StRd;
          end
        end
      end
      StWr:    if (w_wr_fin) w_state_d = StIdle;
      StRd:    if (w_ar_hs) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Channel valids and response readies.
  always_comb begin
    ram_axi_awvalid = ~srst & (r_state == StWr) & ~r_aw_done;
    ram_axi_wvalid  = ~srst & (r_state == StWr) & ~r_w_done;
    ram_axi_arvalid = ~srst & (r_state == StRd);
    ram_axi_bready  = ~srst;
    ram_axi_rready  = ~srst;
  end

  // Fixed single-beat AXI attributes; payload comes straight from the queue head.
  assign ram_axi_awid    = '0;
  assign ram_axi_awaddr  = w_head.addr;
  assign ram_axi_awlen   = 8'd0;
  assign ram_axi_awsize  = AxiSize;
  assign ram_axi_awburst = BURST_INCR;
  assign ram_axi_awlock  = 1'b0;
  assign ram_axi_awcache = 4'd0;
  assign ram_axi_awprot  = 3'd0;
  assign ram_axi_wdata   = w_head.data;
  assign ram_axi_wstrb   = '1;
  assign ram_axi_wlast   = 1'b1;
  assign ram_axi_arid    = '0;
  assign ram_axi_araddr  = w_head.addr;
  assign ram_axi_arlen   = 8'd0;
  assign ram_axi_arsize  = AxiSize;
  assign ram_axi_arburst = BURST_INCR;
  assign ram_axi_arlock  = 1'b0;
  assign ram_axi_arcache = 4'd0;
  assign ram_axi_arprot  = 3'd0;

  // AW and W complete independently; both flags clear once the write is retired.
  always_ff @(posedge aclk) begin
    if (srst || w_wr_fin) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  // Outstanding read/write counters.
  always_ff @(posedge aclk) begin
    if (srst) begin
      r_rd_pend <= '0;
      r_wr_pend <= '0;
    end else begin
      unique case ({w_ar_hs, w_r_done})
        2'b10:   r_rd_pend <= r_rd_pend + PendOne;
        2'b01:   r_rd_pend <= r_rd_pend - PendOne;
        default: r_rd_pend <= r_rd_pend;
      endcase
      unique case ({w_wr_fin, w_b_hs})
        2'b10:   r_wr_pend <= r_wr_pend + PendOne;
        2'b01:   r_wr_pend <= r_wr_pend - PendOne;
        default: r_wr_pend <= r_wr_pend;
      endcase
    end
  end

  // Registered read return, one cycle after the R handshake.
  always_ff @(posedge aclk) begin
    if (srst) begin
      mem_rd_valid <= 1'b0;
      mem_rd_data  <= '0;
    end else begin
      mem_rd_valid <= w_r_hs;
      if (w_r_hs) mem_rd_data <= ram_axi_rdata;
    end
  end

`ifdef AXI_RESP_CHECK_EN
  logic w_unused;
  assign w_unused = ^{ram_axi_bid, ram_axi_rid};

  // Sticky error on bad responses or malformed commands.
  always_ff @(posedge aclk) begin
    if (srst) begin
      mem_error <= 1'b0;
    end else if ((w_b_hs && (ram_axi_bresp != RESP_OKAY)) ||
                 (w_r_hs && (ram_axi_rresp != RESP_OKAY)) ||
                 (mem_valid && mem_ready && (mem_rd == mem_wr))) begin
      mem_error <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^{ram_axi_bid, ram_axi_rid, ram_axi_bresp, ram_axi_rresp};
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_mem_port.sv
// Directed self-checking bench for axi4_mem_port; the slave side is driven by hand.
module tb_axi4_mem_port;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int IW = 8;
`ifdef AXI_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          srst;
  logic          mem_valid, mem_ready, mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic          mem_error;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awlock, arlock;
  logic [3:0]    awcache, arcache;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;

  always #5 aclk = ~aclk;

  axi4_mem_port dut (
    .aclk (aclk), .srst (srst),
    .mem_valid (mem_valid), .mem_ready (mem_ready), .mem_rd (mem_rd), .mem_wr (mem_wr),
    .mem_addr (mem_addr), .mem_wr_data (mem_wr_data), .mem_rd_valid (mem_rd_valid),
    .mem_rd_data (mem_rd_data), .mem_error (mem_error),
    .ram_axi_awid (awid), .ram_axi_awaddr (awaddr), .ram_axi_awlen (awlen),
    .ram_axi_awsize (awsize), .ram_axi_awburst (awburst), .ram_axi_awlock (awlock),
    .ram_axi_awcache (awcache), .ram_axi_awprot (awprot), .ram_axi_awvalid (awvalid),
    .ram_axi_awready (awready),
    .ram_axi_wdata (wdata), .ram_axi_wstrb (wstrb), .ram_axi_wlast (wlast),
    .ram_axi_wvalid (wvalid), .ram_axi_wready (wready),
    .ram_axi_bid (bid), .ram_axi_bresp (bresp), .ram_axi_bvalid (bvalid),
    .ram_axi_bready (bready),
    .ram_axi_arid (arid), .ram_axi_araddr (araddr), .ram_axi_arlen (arlen),
    .ram_axi_arsize (arsize), .ram_axi_arburst (arburst), .ram_axi_arlock (arlock),
    .ram_axi_arcache (arcache), .ram_axi_arprot (arprot), .ram_axi_arvalid (arvalid),
    .ram_axi_arready (arready),
    .ram_axi_rid (rid), .ram_axi_rdata (rdata), .ram_axi_rresp (rresp),
    .ram_axi_rlast (rlast), .ram_axi_rvalid (rvalid), .ram_axi_rready (rready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Handshake monitor.
  int            n_aw = 0, n_w = 0, n_b = 0, n_ar = 0;
  logic [AW-1:0] last_awaddr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic          last_wlast = 1'b0;
  always @(posedge aclk) begin
    if (awvalid && awready) begin n_aw <= n_aw + 1; last_awaddr <= awaddr; end
    if (wvalid && wready) begin n_w <= n_w + 1; last_wdata <= wdata; last_wlast <= wlast; end
    if (bvalid && bready) n_b <= n_b + 1;
    if (arvalid && arready) n_ar <= n_ar + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    for (int i = 0; i < 100 && !mem_ready; i++) tick();
    if (!mem_ready) check_eq("push_ready_timeout", mem_ready, 1);
    mem_valid = 1'b1; mem_rd = rd; mem_wr = wr; mem_addr = a; mem_wr_data = d;
    tick();
    mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic b_beat(input logic [1:0] resp);
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  int  base_aw, base_w, base_b, base_ar;
  logic flag;

  initial begin
    srst = 1'b1; mem_valid = 0; mem_rd = 0; mem_wr = 0; mem_addr = '0; mem_wr_data = '0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
    bid = '0; rid = '0; bresp = 2'b00; rresp = 2'b00; rdata = '0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_mem_ready", mem_ready, 0);
    check_eq("rst_bready", bready, 0);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_valids", {awvalid, wvalid, arvalid}, 0);
    check_eq("rst_rd_valid", mem_rd_valid, 0);
    check_eq("rst_rd_data", mem_rd_data, 0);
    check_eq("rst_error", mem_error, 0);
    srst = 1'b0;
    tick();
    check_eq("post_rst_ready", mem_ready, 1);
    check_eq("post_rst_breadyrready", {bready, rready}, 2'b11);

    // 1: write, AW ready three cycles ahead of W ready
    base_aw = n_aw; base_w = n_w;
    push(0, 1, 16'h0010, 32'hDEADBEEF);
    for (int i = 0; i < 20 && !awvalid; i++) tick();
    check_eq("t1_aw_valid", {awvalid, wvalid}, 2'b11);
    check_eq("t1_aw_fields", {awlen, awsize, awburst, awlock, awcache, awprot},
             {8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0});
    check_eq("t1_awaddr", awaddr, 16'h0010);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    check_eq("t1_aw_drop", {awvalid, wvalid}, 2'b01);
    tick();
    tick();
    check_eq("t1_w_hold", {awvalid, wvalid, wdata}, {2'b01, 32'hDEADBEEF});
    check_eq("t1_wstrb_wlast", {wstrb, wlast}, 5'b11111);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    check_eq("t1_w_drop", {awvalid, wvalid}, 2'b00);
    check_eq("t1_wr_pend_1", dut.r_wr_pend, 1);
    repeat (3) tick();
    check_eq("t1_beats", {n_aw - base_aw, n_w - base_w}, {32'd1, 32'd1});
    check_eq("t1_aw_w_data", {last_awaddr, last_wdata, last_wlast},
             {16'h0010, 32'hDEADBEEF, 1'b1});
    b_beat(2'b00);
    check_eq("t1_wr_pend_0", dut.r_wr_pend, 0);

    // 2: write then read the same address; read waits for the B beat
    base_w = n_w;
    awready = 1'b1; wready = 1'b1;
    push(0, 1, 16'h0020, 32'hA5A5A5A5);
    push(1, 0, 16'h0020, 32'h0);
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      flag = flag | arvalid;
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    check_eq("t2_ar_before_b", flag, 0);
    check_eq("t2_w_done", n_w - base_w, 1);
    b_beat(2'b00);
    for (int i = 0; i < 10 && !arvalid; i++) tick();
    check_eq("t2_ar", {arvalid, araddr, arlen, arsize, arburst}, {1'b1, 16'h0020, 8'd0, 3'd2, 2'b01});
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("t2_rd_pend_1", dut.r_rd_pend, 1);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hA5A5A5A5; rresp = 2'b00;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    check_eq("t2_rd_ret", {mem_rd_valid, mem_rd_data}, {1'b1, 32'hA5A5A5A5});
    tick();
    check_eq("t2_rd_pulse", mem_rd_valid, 0);

    // 3: six reads against MAX_OUTSTANDING=4
    base_ar = n_ar;
    arready = 1'b1;
    for (int i = 0; i < 6; i++) push(1, 0, 16'h0100 + 16'(4 * i), 32'h0);
    repeat (8) tick();
    check_eq("t3_ar_cap", n_ar - base_ar, 4);
    check_eq("t3_ar_low", arvalid, 0);
    check_eq("t3_rd_pend", dut.r_rd_pend, 4);
    for (int k = 0; k < 6; k++) begin
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1000 + 32'(k);
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      check_eq("t3_rd_ret", {mem_rd_valid, mem_rd_data}, {1'b1, 32'h1000 + 32'(k)});
      tick();
      tick();
    end
    arready = 1'b0;
    check_eq("t3_ar_total", n_ar - base_ar, 6);
    check_eq("t3_rd_pend_0", dut.r_rd_pend, 0);

    // 4: fill the queue with the slave stalled
    base_w = n_w; base_b = n_b;
    for (int i = 0; i < 15; i++) push(0, 1, 16'h0200 + 16'(4 * i), 32'h4000 + 32'(i));
    check_eq("t4_ready_15", mem_ready, 1);
    push(0, 1, 16'h023C, 32'h400F);
    check_eq("t4_full", mem_ready, 0);
    tick();
    check_eq("t4_full_hold", mem_ready, 0);
    awready = 1'b1; wready = 1'b1;
    tick();
    check_eq("t4_ready_after_pop", mem_ready, 1);
    for (int i = 0; i < 300 && (n_b - base_b) < 16; i++) begin
      bvalid = (n_w > n_b);
      tick();
    end
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    check_eq("t4_drain", {n_w - base_w, n_b - base_b}, {32'd16, 32'd16});
    check_eq("t4_last_w", {last_awaddr, last_wdata}, {16'h023C, 32'h400F});
    check_eq("t4_wr_pend_0", dut.r_wr_pend, 0);

    // 5: illegal commands, then an SLVERR write response
    base_aw = n_aw; base_ar = n_ar; base_w = n_w;
    push(1, 1, 16'h0300, 32'h1);
    push(0, 0, 16'h0304, 32'h2);
    repeat (4) tick();
    check_eq("t5_illegal_dropped", {n_aw - base_aw, n_ar - base_ar}, 64'd0);
    check_eq("t5_illegal_ready", mem_ready, 1);
    check_eq("t5_illegal_err", mem_error, EXP_ERR);
    awready = 1'b1; wready = 1'b1;
    push(0, 1, 16'h0030, 32'h0BADF00D);
    for (int i = 0; i < 20 && (n_w - base_w) < 1; i++) tick();
    awready = 1'b0; wready = 1'b0;
    b_beat(2'b10);
    check_eq("t5_slverr", mem_error, EXP_ERR);
    check_eq("t5_wr_pend_0", dut.r_wr_pend, 0);
    repeat (5) tick();
    check_eq("t5_sticky", mem_error, EXP_ERR);

    // 6: reset while a write is on AW
    push(0, 1, 16'h0040, 32'hCAFE0001);
    for (int i = 0; i < 20 && !awvalid; i++) tick();
    check_eq("t6_aw_up", awvalid, 1);
    srst = 1'b1;
    tick();
    check_eq("t6_valids", {awvalid, wvalid, arvalid}, 0);
    check_eq("t6_ready", {mem_ready, bready, rready}, 0);
    check_eq("t6_counters", {dut.r_rd_pend, dut.r_wr_pend}, 0);
    check_eq("t6_outputs", {mem_error, mem_rd_valid, mem_rd_data}, 0);
    srst = 1'b0;
    tick();
    check_eq("t6_ready_back", mem_ready, 1);
    check_eq("t6_idle", {awvalid, wvalid, arvalid}, 0);
    base_w = n_w;
    awready = 1'b1; wready = 1'b1;
    push(0, 1, 16'h0050, 32'h12345678);
    for (int i = 0; i < 20 && (n_w - base_w) < 1; i++) tick();
    awready = 1'b0; wready = 1'b0;
    check_eq("t6_fresh_w", {last_awaddr, last_wdata}, {16'h0050, 32'h12345678});
    check_eq("t6_fresh_pend", dut.r_wr_pend, 1);
    b_beat(2'b00);
    check_eq("t6_fresh_done", dut.r_wr_pend, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
